// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch FSM with skid-free HOLD handshake.
// Optional 16-entry direct-mapped instruction cache enabled by defining ICACHE_EN.
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_a_o,
    input  logic [7:0]  mem_din_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);
    typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, F4, HOLD} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_new, hit_inst;
    logic        replay_q, replay_d;
    logic        capturing, fetching, replay_act, hit;
    logic [1:0]  byte_idx, a_off;
    logic [2:0]  st;
    assign st         = state_q;
    assign capturing  = state_q inside {F1, F2, F3, F4};
    assign fetching   = state_q inside {F0, F1, F2, F3};
    assign byte_idx   = st[1:0] - 2'd2;
    // After a stall the byte that was in flight is lost, so the previous address is reissued once.
    assign replay_act = replay_q && rdy_i && capturing;
    assign a_off      = replay_act ? byte_idx : st[1:0] - 2'd1;
    assign inst_new   = (inst_q & ~(32'hFF << {byte_idx, 3'b0})) | ({24'd0, mem_din_i} << {byte_idx, 3'b0});
    assign mem_req_o  = !rst && (replay_act || (fetching && !hit));
    assign mem_a_o    = mem_req_o ? pc_q + {30'd0, a_off} : '0;
    assign if_valid_o = !rst && state_q == HOLD;
    assign if_pc_o    = rst ? '0 : pc_q;
    assign if_inst_o  = rst ? '0 : inst_q;
`ifdef ICACHE_EN
    logic [15:0] valid_q, valid_d;
    logic [11:0] tag_q [16];
    logic [31:0] data_q [16];
    logic [3:0]  idx;
    logic        cache_we;
    assign idx      = pc_q[5:2];
    assign hit      = state_q == F0 && valid_q[idx] && tag_q[idx] == pc_q[17:6];
    assign hit_inst = data_q[idx];
    assign cache_we = !rst && rdy_i && !branch_i && !replay_act && state_q == F4;
    assign valid_d  = cache_we ? valid_q | (16'd1 << idx) : valid_q;
    always_ff @(posedge clk) begin
        valid_q <= rst ? '0 : valid_d;
        if (cache_we) begin
            tag_q[idx]  <= pc_q[17:6];
            data_q[idx] <= inst_new;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_inst = '0;
`endif
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        replay_d = replay_q;
        if (!rdy_i) begin
            replay_d = replay_q || capturing;
        end else if (branch_i) begin
            state_d  = F0;
            pc_d     = branch_target_i;
            replay_d = 1'b0;
        end else if (replay_act) begin
            replay_d = 1'b0;
        end else if (state_q == HOLD) begin
            state_d = if_ready_i ? F0 : HOLD;
            pc_d    = if_ready_i ? pc_q + 32'd4 : pc_q;
        end else if (hit) begin
            state_d = HOLD;
            inst_d  = hit_inst;
        end else begin
            state_d = state_e'(st + 3'd1);
            inst_d  = capturing ? inst_new : inst_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            replay_q <= replay_d;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch; expected instructions come from the bench's byte memory.
module tb_if_fetch;
    logic        clk = 1'b0, rst = 1'b1, rdy_i = 1'b1, branch_i = 1'b0, if_ready_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [7:0]  mem_din_i = '0;
    logic        mem_req_o, if_valid_o;
    logic [31:0] mem_a_o, if_pc_o, if_inst_o;
    logic [7:0]  mem [4096];
    int          checks = 0, errors = 0;
    typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
    exp_t        sb[$];
`ifdef ICACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    if_fetch dut (
        .clk(clk), .rst(rst), .rdy_i(rdy_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
        .mem_req_o(mem_req_o), .mem_a_o(mem_a_o), .mem_din_i(mem_din_i), .if_valid_o(if_valid_o),
        .if_ready_i(if_ready_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_din_i <= mem[mem_a_o[11:0]];

    function automatic logic [31:0] model(input logic [31:0] a);
        return {mem[12'(a + 32'd3)], mem[12'(a + 32'd2)], mem[12'(a + 32'd1)], mem[a[11:0]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        sb.push_back('{pc, model(pc)});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!if_valid_o && n < 64) begin
            tick;
            n++;
        end
        chk("valid_timeout", {31'd0, if_valid_o}, 32'd1);
    endtask

    task automatic accept(input logic br, input logic [31:0] tgt);
        exp_t e;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("xfer_pc", if_pc_o, e.pc);
            chk("xfer_inst", if_inst_o, e.inst);
        end
        if_ready_i = 1'b1;
        branch_i = br;
        branch_target_i = tgt;
        tick;
        if_ready_i = 1'b0;
        branch_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] hp, hi;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        repeat (3) tick;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_a_o, 32'd0);
        chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'd0, mem_req_o}, 32'd0);
        tick;
        chk("f0_req", {31'd0, mem_req_o}, 32'd1);
        chk("f0_addr", mem_a_o, 32'd0);
        expect_fetch(32'd0);
        for (int k = 1; k < 4; k++) begin
            tick;
            chk("f_addr", mem_a_o, 32'(k));
        end
        tick;
        chk("f4_req", {31'd0, mem_req_o}, 32'd0);
        wait_valid(n);
        chk("miss_latency", 32'(4 + n), 32'd5);
        chk("first_inst", if_inst_o, 32'h00100513);
        hp = if_pc_o;
        hi = if_inst_o;
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("bp_valid", {31'd0, if_valid_o}, 32'd1);
            chk("bp_pc", if_pc_o, hp);
            chk("bp_inst", if_inst_o, hi);
            chk("bp_req", {31'd0, mem_req_o}, 32'd0);
        end
        accept(1'b0, '0);
        chk("post_xfer_valid", {31'd0, if_valid_o}, 32'd0);
        expect_fetch(32'd4);
        chk("seq_addr", mem_a_o, 32'd4);
        for (int k = 5; k < 8; k++) begin
            tick;
            chk("seq_addr", mem_a_o, 32'(k));
        end
        wait_valid(n);
        accept(1'b0, '0);
        expect_fetch(32'd8);
        tick;
        tick;
        chk("f2_addr", mem_a_o, 32'd10);
        branch_i = 1'b1;
        branch_target_i = 32'h100;
        tick;
        branch_i = 1'b0;
        void'(sb.pop_back());
        expect_fetch(32'h100);
        chk("br_valid", {31'd0, if_valid_o}, 32'd0);
        chk("br_addr", mem_a_o, 32'h100);
        for (int k = 1; k < 4; k++) begin
            tick;
            chk("br_addr", mem_a_o, 32'h100 + 32'(k));
        end
        wait_valid(n);
        accept(1'b0, '0);
        expect_fetch(32'h104);
        chk("stall_f0", mem_a_o, 32'h104);
        tick;
        chk("stall_f1", mem_a_o, 32'h105);
        rdy_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stall_addr", mem_a_o, 32'h105);
            chk("stall_req", {31'd0, mem_req_o}, 32'd1);
        end
        rdy_i = 1'b1;
        wait_valid(n);
        accept(1'b0, '0);
        expect_fetch(32'h108);
        wait_valid(n);
        accept(1'b1, 32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC);
        chk("wrap_valid", {31'd0, if_valid_o}, 32'd0);
        chk("wrap_addr", mem_a_o, 32'hFFFF_FFFC);
        wait_valid(n);
        accept(1'b0, '0);
        expect_fetch(32'd0);
        chk("wrap_pc", if_pc_o, 32'd0);
        chk("wrap_next_addr", mem_a_o, 32'd0);
        wait_valid(n);
        accept(1'b0, '0);
        branch_i = 1'b1;
        branch_target_i = 32'h40;
        tick;
        branch_i = 1'b0;
        expect_fetch(32'h40);
        wait_valid(n);
        accept(1'b1, 32'h40);
        expect_fetch(32'h40);
        chk("loop_f0_req", {31'd0, mem_req_o}, CACHE ? 32'd0 : 32'd1);
        wait_valid(n);
        chk("loop_latency", 32'(n), CACHE ? 32'd1 : 32'd5);
        accept(1'b0, '0);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("midrst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
        chk("midrst_inst", if_inst_o, 32'd0);
        chk("midrst_pc", if_pc_o, 32'd0);
        rst = 1'b0;
        sb.delete();
        expect_fetch(32'd0);
        tick;
        chk("midrst_addr", mem_a_o, 32'd0);
        wait_valid(n);
        accept(1'b0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
